// File: rtl/alu_seq.sv
// alu_seq -- registered multi-bit ALU with valid/ready handshakes on both
// sides. Successor to the 1-bit ALU slice and uses the same 3-bit control
// encoding. It sits between decode and writeback in the lab datapath.
//
// Build option: define ALU_MUL_EN to include an iterative unsigned shift-add
// multiplier on control 001. It produces one partial product per cycle and
// has a latency of WIDTH+1 edges. Without the macro, control 001 completes in
// one cycle with out=0 and illegal=1. No multiplier state is built in that case.
//
// Ports:
//   clock, reset         single clock; synchronous active-high reset
//   in_valid / in_ready  operand handshake (A, B, control)
//   A, B [WIDTH-1:0]     operands
//   control [2:0]        000 A, 001 MUL, 010 A+B, 011 A-B, 100 A&B,
//                        101 A|B, 110 ~(A|B), 111 A^B
//   out_valid/out_ready  result handshake
//   out [WIDTH-1:0]      registered result
//   zero, negative       registered flags of out (meaningful with out_valid)
//   overflow             signed add/sub overflow, or nonzero high product
//   illegal              control not supported in this build
module alu_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       control,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             zero,
  output logic             negative,
  output logic             overflow,
  output logic             illegal
);

  logic             accept;
  logic             write_single;
  logic [WIDTH-1:0] alu_result;
  logic             alu_ovf;
  logic             alu_illegal;
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;

  assign accept = in_valid & in_ready;
  assign sum    = A + B;
  assign diff   = A - B;

  // Single-cycle datapath, evaluated directly on the presented operands.
  always_comb begin
    alu_result  = '0;
    alu_ovf     = 1'b0;
    alu_illegal = 1'b0;
    case (control)
      3'b000: alu_result = A;
      3'b001: begin
`ifndef ALU_MUL_EN
        alu_illegal = 1'b1;
`endif
      end
      3'b010: begin
        alu_result = sum;
        alu_ovf    = (A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
      end
      3'b011: begin
        alu_result = diff;
        alu_ovf    = (A[WIDTH-1] != B[WIDTH-1]) && (diff[WIDTH-1] != A[WIDTH-1]);
      end
      3'b100:  alu_result = A & B;
      3'b101:  alu_result = A | B;
      3'b110:  alu_result = ~(A | B);
      default: alu_result = A ^ B;
    endcase
  end

`ifdef ALU_MUL_EN
  typedef enum logic {IDLE, MUL} state_t;

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t             state;
  state_t             state_next;
  logic               mul_start;
  logic               mul_done;
  logic [CW-1:0]      count;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_next;

  assign mul_start    = accept && (control == 3'b001);
  assign write_single = accept && !mul_start;
  assign mul_done     = (state == MUL) && (count == LAST);
  assign acc_next     = mplier[0] ? acc + mcand : acc;
  assign in_ready     = (state == IDLE) & (!out_valid | out_ready);

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (mul_start) state_next = MUL;
      default: if (mul_done)  state_next = IDLE;
    endcase
  end

  // Shift-add: the multiplicand moves left and the multiplier moves right.
  // The LSB of the multiplier selects each partial product.
  always_ff @(posedge clock) begin
    if (reset) begin
      count  <= '0;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
    end else if (mul_start) begin
      count  <= '0;
      mcand  <= {{WIDTH{1'b0}}, A};
      mplier <= B;
      acc    <= '0;
    end else if (state == MUL) begin
      count  <= count + CW'(1);
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      acc    <= acc_next;
    end
  end
`else
  assign write_single = accept;
  assign in_ready     = !out_valid | out_ready;
`endif

  // Result register. Once out_valid is set, it holds until the consumer takes the result.
  // A new result written on the drain edge keeps out_valid set.
  always_ff @(posedge clock) begin
    if (reset) begin
      out       <= '0;
      zero      <= 1'b0;
      negative  <= 1'b0;
      overflow  <= 1'b0;
      illegal   <= 1'b0;
      out_valid <= 1'b0;
    end else if (write_single) begin
      out       <= alu_result;
      zero      <= (alu_result == '0);
      negative  <= alu_result[WIDTH-1];
      overflow  <= alu_ovf;
      illegal   <= alu_illegal;
      out_valid <= 1'b1;
`ifdef ALU_MUL_EN
    end else if (mul_done) begin
      out       <= acc_next[WIDTH-1:0];
      zero      <= (acc_next[WIDTH-1:0] == '0);
      negative  <= acc_next[WIDTH-1];
      overflow  <= (acc_next[2*WIDTH-1:WIDTH] != '0);
      illegal   <= 1'b0;
      out_valid <= 1'b1;
`endif
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq -- self-checking bench for alu_seq (WIDTH=32). It combines directed
// cases with randomized operations. The expected results come from a
// behavioural model that uses plain wide arithmetic.
module tb_alu_seq;
  localparam int W = 32;
  localparam longint MAXS = (longint'(1) <<< (W - 1)) - 1;
  localparam longint MINS = -(longint'(1) <<< (W - 1));

  logic         clock = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic [2:0]   control;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out;
  logic         zero;
  logic         negative;
  logic         overflow;
  logic         illegal;

  int checks = 0;
  int passed = 0;

  alu_seq #(.WIDTH(W)) dut (
    .clock    (clock),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .A        (A),
    .B        (B),
    .control  (control),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out      (out),
    .zero     (zero),
    .negative (negative),
    .overflow (overflow),
    .illegal  (illegal)
  );

  always #5 clock = ~clock;

  // Reference: returns {result, zero, negative, overflow, illegal}
  function automatic logic [W+3:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic [2:0] c);
    longint      sa = longint'($signed(a));
    longint      sb = longint'($signed(b));
    longint      s;
    logic [63:0] p;
    logic [W-1:0] r = '0;
    logic        v = 1'b0;
    logic        il = 1'b0;
    case (c)
      3'd0: r = a;
      3'd1: begin
`ifdef ALU_MUL_EN
        p = 64'(a) * 64'(b);
        r = p[W-1:0];
        v = (p[2*W-1:W] != 0);
`else
        il = 1'b1;
`endif
      end
      3'd2: begin s = sa + sb; r = s[W-1:0]; v = (s > MAXS) || (s < MINS); end
      3'd3: begin s = sa - sb; r = s[W-1:0]; v = (s > MAXS) || (s < MINS); end
      3'd4: r = a & b;
      3'd5: r = a | b;
      3'd6: r = ~(a | b);
      default: r = a ^ b;
    endcase
    return {r, (r == 0), r[W-1], v, il};
  endfunction

  function automatic logic [W+4:0] observed();
    return {out_valid, out, zero, negative, overflow, illegal};
  endfunction

  function automatic logic [W-1:0] rand_operand();
    case ($urandom_range(0, 5))
      0: return 32'h7FFF_FFFF;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'h0;
      default: return $urandom;
    endcase
  endfunction

  function automatic logic [2:0] rand_single_ctl();
    logic [2:0] c = 3'($urandom_range(0, 7));
`ifdef ALU_MUL_EN
    if (c == 3'd1) c = 3'd2;
`endif
    return c;
  endfunction

  task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] c);
    A = a; B = b; control = c; in_valid = 1'b1;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    A = '0; B = '0; control = 3'd0;
    repeat (2) @(posedge clock);
    #1;
    checks++;
    if (observed() !== '0) $display("[TB] FAIL reset_state: got %h expected 0", observed());
    else passed++;
    reset = 1'b0;
    step();
    checks++;
    if ({out_valid, in_ready} !== 2'b01)
      $display("[TB] FAIL reset_idle: got valid/ready %b expected 01", {out_valid, in_ready});
    else passed++;
  endtask

  task automatic test_add_overflow();
    logic [W+4:0] exp = {1'b1, 32'h8000_0000, 1'b0, 1'b1, 1'b1, 1'b0};
    drive(32'h7FFF_FFFF, 32'h1, 3'b010);
    step();
    in_valid = 1'b0;
    checks++;
    if (observed() !== exp) $display("[TB] FAIL add_overflow: got %h expected %h", observed(), exp);
    else passed++;
    step();
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] a, b;
    logic [2:0]   c;
    logic [W+4:0] exp;
    out_ready = 1'b1;
    drive(32'h5, 32'h5, 3'b011);
    step();
    exp = {1'b1, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0};
    checks++;
    if (observed() !== exp || in_ready !== 1'b1)
      $display("[TB] FAIL b2b_sub: got %h rdy %b expected %h rdy 1", observed(), in_ready, exp);
    else passed++;
    drive(32'hF0, 32'h0F, 3'b111);
    step();
    exp = {1'b1, 32'hFF, 1'b0, 1'b0, 1'b0, 1'b0};
    checks++;
    if (observed() !== exp) $display("[TB] FAIL b2b_xor: got %h expected %h", observed(), exp);
    else passed++;
    for (int i = 0; i < 60; i++) begin
      a = rand_operand(); b = rand_operand(); c = rand_single_ctl();
      drive(a, b, c);
      step();
      exp = {1'b1, model(a, b, c)};
      checks++;
      if (observed() !== exp)
        $display("[TB] FAIL b2b_rand ctl=%0d a=%h b=%h: got %h expected %h", c, a, b, observed(), exp);
      else passed++;
    end
    in_valid = 1'b0;
    step();
    checks++;
    if (out_valid !== 1'b0) $display("[TB] FAIL drain_clear: got out_valid %b expected 0", out_valid);
    else passed++;
  endtask

  task automatic test_hold();
    logic [W-1:0] a2, b2;
    logic [2:0]   c2;
    logic [W+4:0] exp1, exp2;
    for (int r = 0; r < 4; r++) begin
      out_ready = 1'b0;
      A = rand_operand(); B = rand_operand();
      drive(A, B, 3'b100);
      exp1 = {1'b1, model(A, B, 3'b100)};
      step();
      a2 = rand_operand(); b2 = rand_operand(); c2 = rand_single_ctl();
      drive(a2, b2, c2);
      exp2 = {1'b1, model(a2, b2, c2)};
      for (int k = 0; k < 3; k++) begin
        step();
        checks++;
        if (observed() !== exp1 || in_ready !== 1'b0)
          $display("[TB] FAIL hold_stable: got %h rdy %b expected %h rdy 0", observed(), in_ready, exp1);
        else passed++;
      end
      out_ready = 1'b1;
      #1;
      checks++;
      if (in_ready !== 1'b1) $display("[TB] FAIL hold_ready: got %b expected 1", in_ready);
      else passed++;
      step();
      in_valid = 1'b0;
      checks++;
      if (observed() !== exp2) $display("[TB] FAIL drain_accept: got %h expected %h", observed(), exp2);
      else passed++;
      step();
    end
  endtask

`ifdef ALU_MUL_EN
  task automatic test_mul_op(input logic [W-1:0] a, input logic [W-1:0] b);
    int           edges;
    logic [W+4:0] exp = {1'b1, model(a, b, 3'b001)};
    out_ready = 1'b1;
    drive(a, b, 3'b001);
    step();
    in_valid = 1'b0;
    edges = 1;
    while (out_valid !== 1'b1 && edges < 40) begin
      checks++;
      if (in_ready !== 1'b0) $display("[TB] FAIL mul_busy_ready: got %b expected 0", in_ready);
      else passed++;
      step();
      edges++;
    end
    checks++;
    if (edges != W + 1) $display("[TB] FAIL mul_latency: got %0d edges expected %0d", edges, W + 1);
    else passed++;
    checks++;
    if (observed() !== exp) $display("[TB] FAIL mul_result a=%h b=%h: got %h expected %h", a, b, observed(), exp);
    else passed++;
    step();
  endtask

  task automatic test_mul();
    test_mul_op(32'h1_0000, 32'h1_0000);
    for (int i = 0; i < 4; i++) test_mul_op(rand_operand(), $urandom_range(0, 65535));
    test_mul_op($urandom, $urandom);
  endtask

  task automatic test_reset_mid_mul();
    logic seen = 1'b0;
    out_ready = 1'b1;
    drive(32'h1234, 32'h5678, 3'b001);
    step();
    in_valid = 1'b0;
    repeat (5) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++;
    if ({out_valid, in_ready} !== 2'b01)
      $display("[TB] FAIL mul_reset_idle: got valid/ready %b expected 01", {out_valid, in_ready});
    else passed++;
    for (int k = 0; k < 40; k++) begin
      step();
      if (out_valid === 1'b1) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) $display("[TB] FAIL mul_reset_discard: got result %b expected 0", seen);
    else passed++;
  endtask
`else
  task automatic test_illegal();
    logic [W+4:0] exp = {1'b1, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1};
    out_ready = 1'b1;
    drive($urandom, $urandom, 3'b001);
    step();
    in_valid = 1'b0;
    checks++;
    if (observed() !== exp) $display("[TB] FAIL illegal_mul: got %h expected %h", observed(), exp);
    else passed++;
    step();
  endtask
`endif

  initial begin
    test_reset();
    test_add_overflow();
    test_back_to_back();
    test_hold();
`ifdef ALU_MUL_EN
    test_mul();
    test_reset_mid_mul();
`else
    test_illegal();
`endif
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
